// File: rtl/ac97_crac_pkg.sv
// Shared types and command-field constants for the AC97 CRA arbiter.
// AC97_CRAC_TMO_EN adds the HALT state used after a CRA completion timeout.
package ac97_crac_pkg;

  localparam int unsigned CMD_RD_BIT = 31;
  localparam int unsigned CMD_IDX_HI = 22;
  localparam int unsigned CMD_IDX_LO = 16;
  localparam int unsigned CMD_DATA_W = 16;

  // Keeps the read flag, register index and data; bits 30:23 are forced to 0.
  localparam logic [31:0] CMD_KEEP_MASK = 32'h807F_FFFF;

  localparam logic [15:0] TMO_RD_VAL = 16'hFFFF;

`ifdef AC97_CRAC_TMO_EN
  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StHalt} crac_state_e;
`else
  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone} crac_state_e;
`endif

endpackage

// File: rtl/ac97_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, cyclic.
module ac97_rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] jj;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j  = (32'(ptr_i) + k) % NREQ;
      jj = j[IW-1:0];
      if (!found && req_i[jj]) begin
        found     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/ac97_crac_arb.sv
// Round-robin arbiter/sequencer sharing the AC97 codec register access channel.
// Define AC97_CRAC_TMO_EN to abort a stalled CRA access after TMO_CYC cycles.
module ac97_crac_arb
  import ac97_crac_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*32-1:0] req_cmd,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    gnt,
  output logic [15:0]        rd_data,
  output logic               busy,
  output logic               err,
  output logic               crac_we,
  output logic [31:0]        crac_out,
  input  logic [15:0]        crac_din,
  input  logic               crac_wr_done,
  input  logic               crac_rd_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TMO_CYC < 2) begin : g_bad_cfg
    $error("ac97_crac_arb: NREQ must be 2..8 and TMO_CYC at least 2");
  end

  crac_state_e     state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            busy_q, busy_d, crac_we_q, crac_we_d;
  logic [31:0]     crac_out_q, crac_out_d, sel_cmd;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic            arb_vld, is_rd, cra_cmpl;

  ac97_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign sel_cmd  = req_cmd[{arb_idx, 5'b0} +: 32];
  assign is_rd    = crac_out_q[CMD_RD_BIT];
  // Only the completion matching the command type in flight counts.
  assign cra_cmpl = is_rd ? crac_rd_done : crac_wr_done;

`ifdef AC97_CRAC_TMO_EN
  localparam int unsigned CW = $clog2(TMO_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    crac_we_d  = 1'b0;
    crac_out_d = crac_out_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
`ifdef AC97_CRAC_TMO_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (arb_vld) begin
          gnt_d      = arb_gnt;
          idx_d      = arb_idx;
          crac_out_d = sel_cmd & CMD_KEEP_MASK;
          crac_we_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
`ifdef AC97_CRAC_TMO_EN
        cnt_d   = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (cra_cmpl) begin
          if (is_rd) rd_data_d = crac_din;
          done_d  = gnt_q;
          state_d = StDone;
        end
`ifdef AC97_CRAC_TMO_EN
        else if (cnt_q == CW'(TMO_CYC - 1)) begin
          // The CRA cannot be cancelled, so the channel is parked until reset.
          done_d    = gnt_q;
          rd_data_d = TMO_RD_VAL;
          err_d     = 1'b1;
          gnt_d     = '0;
          state_d   = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: begin
        gnt_d      = '0;
        busy_d     = 1'b0;
        crac_out_d = '0;
        ptr_d      = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d    = StIdle;
      end
`ifdef AC97_CRAC_TMO_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      crac_we_q  <= 1'b0;
      crac_out_q <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
`ifdef AC97_CRAC_TMO_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      crac_we_q  <= crac_we_d;
      crac_out_q <= crac_out_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
`ifdef AC97_CRAC_TMO_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign done     = done_q;
  assign gnt      = gnt_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign crac_we  = crac_we_q;
  assign crac_out = crac_out_q;

endmodule

// File: tb/tb_ac97_crac_arb.sv
// Directed plus randomized bench for ac97_crac_arb against a transaction-level model.
module tb_ac97_crac_arb;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*32-1:0] req_cmd;
  logic [N-1:0]  done, gnt;
  logic [15:0]   rd_data, crac_din;
  logic          busy, err, crac_we, crac_wr_done, crac_rd_done;
  logic [31:0]   crac_out;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_ptr = 0;
  logic [15:0] m_rd = '0;

  ac97_crac_arb #(
    .NREQ    (N),
    .TMO_CYC (16)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .req          (req),
    .req_cmd      (req_cmd),
    .done         (done),
    .gnt          (gnt),
    .rd_data      (rd_data),
    .busy         (busy),
    .err          (err),
    .crac_we      (crac_we),
    .crac_out     (crac_out),
    .crac_din     (crac_din),
    .crac_wr_done (crac_wr_done),
    .crac_rd_done (crac_rd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester at or after the model's round-robin pointer.
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {done, gnt, rd_data, busy, err, crac_we}, '0);
    chk({tag, "_cmd"}, crac_out, '0);
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic txn(input logic [N-1:0] r, input logic [31:0] c0, input logic [31:0] c1,
                     input int lat, input logic [15:0] din, input bit stray, input bit drop,
                     input bit keep);
    int g;
    logic [31:0] cmd, exp_out;
    logic rd;
    bit ok;
    req = r;
    req_cmd = {c1, c0};
    g = pick(r);
    cmd = (g == 1) ? c1 : c0;
    exp_out = {cmd[31], 8'h00, cmd[22:0]};
    rd = cmd[31];
    @(posedge clk); @(negedge clk);
    chk("issue_we", crac_we, 1);
    chk("issue_gnt", gnt, 1 << g);
    chk("issue_out", crac_out, exp_out);
    chk("issue_busy", busy, 1);
    req_cmd = ~req_cmd;
    if (drop) req[g] = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      crac_din     = 16'($urandom);
      crac_wr_done = stray && (i == lat / 2) && rd;
      crac_rd_done = stray && (i == lat / 2) && !rd;
      @(negedge clk);
      if (crac_we !== 1'b0 || crac_out !== exp_out || done !== '0 || gnt !== (1 << g)) ok = 1'b0;
    end
    chk("wait_stable", ok, 1);
    @(posedge clk); #1;
    crac_din = din;
    crac_wr_done = !rd;
    crac_rd_done = rd;
    @(posedge clk); #1;
    crac_wr_done = 1'b0;
    crac_rd_done = 1'b0;
    crac_din = 16'($urandom);
    @(negedge clk);
    if (rd) m_rd = din;
    m_ptr = (g + 1) % N;
    chk("done_pulse", done, 1 << g);
    chk("rd_data", rd_data, m_rd);
    if (!keep) req[g] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("after_gnt", {gnt, done, busy}, 0);
    chk("after_out", crac_out, 0);
  endtask

  task automatic idle_check(input int cyc);
    bit ok = 1'b1;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (crac_we !== 1'b0 || gnt !== '0 || done !== '0) ok = 1'b0;
    end
    chk("no_reissue", ok, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_cmd = '0;
    crac_din = '0;
    crac_wr_done = 1'b0;
    crac_rd_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single write with a 40-cycle CRA latency, then a read with a stray write-done.
    txn(2'b01, 32'h0002_8000, 32'($urandom), 40, 16'h1111, 1'b0, 1'b0, 1'b0);
    txn(2'b10, 32'($urandom), 32'h8026_0000, 10, 16'h000F, 1'b1, 1'b0, 1'b0);

    // Contention: both requesters held high over four transactions.
    for (int t = 0; t < 4; t++) begin
      chk("rr_order", pick(2'b11), t % 2);
      txn(2'b11, 32'($urandom), 32'($urandom), $urandom_range(4, 20), 16'($urandom),
          1'($urandom), 1'b0, 1'b1);
    end
    req = '0;

    // Masked command, req withdrawn mid-transaction.
    txn(2'b01, 32'hFFFF_1234, 32'($urandom), 8, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    chk("masked_rd", rd_data, 16'hBEEF);
    idle_check(4);

    for (int t = 0; t < 6; t++)
      txn(2'($urandom_range(1, 3)), 32'($urandom), 32'($urandom), $urandom_range(4, 30),
          16'($urandom), 1'($urandom), 1'b0, 1'b0);

    // Leave the pointer at 1, then reset during WAIT of a read.
    txn(2'b01, 32'h0000_0000, 32'($urandom), 4, 16'h0, 1'b0, 1'b0, 1'b0);
    req = 2'b10;
    req_cmd = {32'h8011_0000, 32'h0};
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    m_ptr = 0;
    m_rd = '0;
    @(posedge clk); #1;
    crac_rd_done = 1'b1;
    crac_din = 16'hABCD;
    @(posedge clk); #1;
    crac_rd_done = 1'b0;
    idle_check(4);
    chk("post_reset_rd", rd_data, 0);
    txn(2'b11, 32'h8005_0000, 32'h8006_0000, 6, 16'h5A5A, 1'b0, 1'b0, 1'b0);

`ifdef AC97_CRAC_TMO_EN
    req = 2'b01;
    req_cmd = {32'h0, 32'h8002_0000};
    @(posedge clk); @(negedge clk);
    chk("tmo_issue", crac_we, 1);
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("tmo_early", done, 0);
    @(posedge clk); @(negedge clk);
    chk("tmo_done", done, 2'b01);
    chk("tmo_rd", rd_data, 16'hFFFF);
    chk("tmo_err", {err, busy, gnt}, {2'b11, 2'b00});
    req = 2'b11;
    idle_check(6);
`else
    chk("err_tied", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ac97_crac_arb.md
Name: ac97_crac_arb

Overview:
- Round-robin arbiter and sequencer in front of the AC97 codec register access (CRA) channel.
- Shares the single CRA command path (crac_we/crac_out in, crac_din/crac_wr_done/crac_rd_done out) between NREQ requesters, e.g. the WISHBONE host slave and the on-chip power-down/init sequencer.
- Issues exactly one codec register read or write at a time, waits for its completion, and returns status and read data to the owning requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TMO_CYC, 4096, cycles waited for CRA completion before abort (used only with AC97_CRAC_TMO_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active low
- req  in  NREQ  per-requester level request; held until matching done
- req_cmd  in  NREQ*32  requester i command at [32i+31:32i]; bit31 = 1 read / 0 write, [22:16] register index, [15:0] write data
- done  out  NREQ  one-cycle completion pulse to the granted requester
- gnt  out  NREQ  one-hot owner of the CRA channel; 0 when idle
- rd_data  out  16  read data, valid in the done cycle of a read
- busy  out  1  transaction in flight
- err  out  1  sticky timeout flag (tied 0 without AC97_CRAC_TMO_EN)
- crac_we  out  1  one-cycle command strobe to the CRA
- crac_out  out  32  command to the CRA; held stable from strobe to completion
- crac_din  in  16  CRA read data
- crac_wr_done  in  1  CRA write completion pulse
- crac_rd_done  in  1  CRA read completion pulse

Behaviour:
- Reset values: done=0, gnt=0, rd_data=0, busy=0, err=0, crac_we=0, crac_out=0, rr pointer=0, state IDLE. Reset mid-transaction discards it; no done pulse is issued.
- States: IDLE, ISSUE, WAIT, DONE (plus HALT with the optional feature).
- IDLE:
  - When any req bit is set, pick the first requester at or after the rr pointer (cyclic).
  - Register gnt, and load crac_out = {cmd[31], 8'h0, cmd[22:16], cmd[15:0]}. Bits 30:23 are forced to 0.
  - Move to ISSUE.
- ISSUE: crac_we=1 for exactly this cycle; busy=1; move to WAIT.
- WAIT:
  - A read completes on crac_rd_done; a write completes on crac_wr_done. The non-matching done is ignored.
  - On completion, capture crac_din into rd_data (reads only; rd_data is unchanged on writes) and move to DONE.
- DONE:
  - done[g]=1 for one cycle. rr pointer = g+1, wrapping to 0 past NREQ-1.
  - gnt, busy and crac_out are cleared on exit to IDLE.
  - The earliest next arbitration is in the following IDLE cycle.
- Latency: req seen in cycle N → crac_we at N+1 → done at the cycle after the CRA done pulse (>= one AC97 frame).
- req is sampled only in IDLE. Dropping req mid-transaction does not cancel it; done is still pulsed. req_cmd is captured at grant, so later changes are ignored.
- Requester handshake: after done, the requester deasserts req or presents a new command. A requester that keeps req high is served again only after the other requesters, so it cannot starve them.
- CRA done pulses arriving in IDLE/ISSUE/DONE are ignored.

Optional Feature:
- Macro: AC97_CRAC_TMO_EN.
- With the macro:
  - A counter of width clog2(TMO_CYC) clears on ISSUE and increments in WAIT.
  - When it reaches TMO_CYC-1 without completion: pulse done[g] with rd_data=16'hFFFF, set err, and enter HALT.
  - HALT grants nothing further (gnt=0, busy=1) until reset, since the CRA has no cancel path.
- Without the macro: no counter, WAIT lasts indefinitely, err tied 0, HALT absent.

Decomposition:
- Package ac97_crac_pkg holds:
  - state enum;
  - command field constants (CMD_RD_BIT=31, CMD_IDX_HI=22, CMD_IDX_LO=16, CMD_DATA_W=16);
  - timeout read value 16'hFFFF.
- Sub-module ac97_rr_arb: combinational round-robin picker. Inputs are req and the pointer; outputs are the one-hot grant and the index.

Test Plan:
- Single write: req=01, cmd0=0x0002_8000; CRA returns crac_wr_done 40 cycles after crac_we.
  - Expect crac_we one cycle after req, crac_out=0x0002_8000 stable throughout, done=01 the cycle after wr_done, gnt=0 after.
- Single read: req=10, cmd1=0x8026_0000, crac_din=0x000F with crac_rd_done.
  - Expect crac_out=0x8026_0000, rd_data=0x000F and done=10.
  - A stray crac_wr_done during WAIT is ignored.
- Contention: req=11 held for 4 transactions.
  - Expect grant order 0,1,0,1 with exactly one crac_we per transaction.
- Command masking and withdrawal: cmd0=0xFFFF_1234.
  - Expect crac_out=0x807F_1234.
  - Drop req0 during WAIT: done[0] still pulses and no reissue follows.
- Reset mid-WAIT: assert rst low.
  - All outputs return to 0 immediately; a later crac_rd_done produces no done.
  - The next req is served starting from requester 0.
- Timeout (AC97_CRAC_TMO_EN, TMO_CYC=16): no CRA done.
  - Expect done with rd_data=0xFFFF 16 cycles after WAIT entry, and err=1.
  - Further reqs get no gnt until reset.
